// File: rtl/fft8_pkg.sv
// ============================================================================
// fft8_pkg : shared constants and state type for the 8-point FFT sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package fft8_pkg;

  localparam int FFT_POINTS           = 8;
  localparam int IDX_W                = 3;
  localparam int DEFAULT_CORE_LATENCY = 3;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    WAIT_OUT = 2'd1,
    RUN      = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fft8_frame_sequencer.sv
// ============================================================================
// fft8_frame_sequencer : gathers 8 complex samples, launches the FFT core,
// captures its results after a fixed latency and streams them out.
// Rev 1.0
// ============================================================================
`default_nettype none

module fft8_frame_sequencer
  import fft8_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int CORE_LATENCY = DEFAULT_CORE_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WIDTH-1:0]            s_real,
  input  logic [WIDTH-1:0]            s_imag,
  output logic [FFT_POINTS*WIDTH-1:0] core_in_real,
  output logic [FFT_POINTS*WIDTH-1:0] core_in_imag,
  output logic                        core_start,
  input  logic [FFT_POINTS*WIDTH-1:0] core_out_real,
  input  logic [FFT_POINTS*WIDTH-1:0] core_out_imag,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WIDTH-1:0]            m_real,
  output logic [WIDTH-1:0]            m_imag,
  output logic [IDX_W-1:0]            m_index,
  output logic                        m_last,
  output logic                        frame_done,
  output logic                        busy
);

  localparam int LAT_W = $clog2(CORE_LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_POINTS - 1);
  localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(CORE_LATENCY);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              out_full_q, out_full_d;

  logic [WIDTH-1:0]  in_re_q  [FFT_POINTS];
  logic [WIDTH-1:0]  in_im_q  [FFT_POINTS];
  logic [WIDTH-1:0]  out_re_q [FFT_POINTS];
  logic [WIDTH-1:0]  out_im_q [FFT_POINTS];

  logic in_we;
  logic capture;
  logic s_fire;
  logic m_fire;
  logic last_out;

  assign s_fire   = s_valid && s_ready && !flush;
  assign m_fire   = out_full_q && m_ready && !flush;
  assign last_out = m_fire && (rd_idx_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    rd_idx_d   = rd_idx_q;
    lat_cnt_d  = lat_cnt_q;
    out_full_d = out_full_q;
    in_we      = 1'b0;
    capture    = 1'b0;

    if (flush) begin
      state_d    = FILL;
      fill_cnt_d = '0;
      rd_idx_d   = '0;
      lat_cnt_d  = '0;
      out_full_d = 1'b0;
    end else begin
      if (m_fire) begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
        if (rd_idx_q == LAST_IDX) begin
          out_full_d = 1'b0;
        end
      end

      case (state_q)
        FILL: begin
          if (s_fire) begin
            in_we      = 1'b1;
            fill_cnt_d = fill_cnt_q + IDX_W'(1);
            // A draining output frame that finishes this very cycle frees the slot.
            if (fill_cnt_q == LAST_IDX) begin
              state_d = (!out_full_q || last_out) ? RUN : WAIT_OUT;
            end
          end
        end
        WAIT_OUT: begin
          if (!out_full_q) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (lat_cnt_q == LAT_MAX) begin
            capture    = 1'b1;
            lat_cnt_d  = '0;
            out_full_d = 1'b1;
            rd_idx_d   = '0;
            state_d    = FILL;
          end else begin
            lat_cnt_d = lat_cnt_q + LAT_W'(1);
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      rd_idx_q   <= '0;
      lat_cnt_q  <= '0;
      out_full_q <= 1'b0;
      for (int n = 0; n < FFT_POINTS; n++) begin
        in_re_q[n]  <= '0;
        in_im_q[n]  <= '0;
        out_re_q[n] <= '0;
        out_im_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      rd_idx_q   <= rd_idx_d;
      lat_cnt_q  <= lat_cnt_d;
      out_full_q <= out_full_d;
      if (in_we) begin
        in_re_q[fill_cnt_q] <= s_real;
        in_im_q[fill_cnt_q] <= s_imag;
      end
      if (capture) begin
        for (int n = 0; n < FFT_POINTS; n++) begin
          out_re_q[n] <= core_out_real[n*WIDTH +: WIDTH];
          out_im_q[n] <= core_out_imag[n*WIDTH +: WIDTH];
        end
      end
    end
  end

  for (genvar n = 0; n < FFT_POINTS; n++) begin : g_pack
    assign core_in_real[n*WIDTH +: WIDTH] = in_re_q[n];
    assign core_in_imag[n*WIDTH +: WIDTH] = in_im_q[n];
  end

  assign s_ready    = (state_q == FILL);
  assign core_start = (state_q == RUN) && (lat_cnt_q == '0);
  assign m_valid    = out_full_q;
  assign m_real     = out_re_q[rd_idx_q];
  assign m_imag     = out_im_q[rd_idx_q];
  assign m_index    = rd_idx_q;
  assign m_last     = out_full_q && (rd_idx_q == LAST_IDX);
  assign frame_done = last_out;
  assign busy       = !((state_q == FILL) && (fill_cnt_q == '0) && !out_full_q);

endmodule

`default_nettype wire

// File: tb/tb_fft8_frame_sequencer.sv
// ============================================================================
// tb_fft8_frame_sequencer : directed + random scoreboard bench with an
// identity pipeline standing in for the FFT core.
// ============================================================================
`default_nettype none

module tb_fft8_frame_sequencer;

  localparam int W  = 16;
  localparam int CL = 3;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              s_valid;
  logic              s_ready;
  logic [W-1:0]      s_real;
  logic [W-1:0]      s_imag;
  logic [8*W-1:0]    core_in_real;
  logic [8*W-1:0]    core_in_imag;
  logic              core_start;
  logic [8*W-1:0]    core_out_real;
  logic [8*W-1:0]    core_out_imag;
  logic              m_valid;
  logic              m_ready;
  logic [W-1:0]      m_real;
  logic [W-1:0]      m_imag;
  logic [2:0]        m_index;
  logic              m_last;
  logic              frame_done;
  logic              busy;

  fft8_frame_sequencer #(.WIDTH(W), .CORE_LATENCY(CL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_real        (s_real),
    .s_imag        (s_imag),
    .core_in_real  (core_in_real),
    .core_in_imag  (core_in_imag),
    .core_start    (core_start),
    .core_out_real (core_out_real),
    .core_out_imag (core_out_imag),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_real        (m_real),
    .m_imag        (m_imag),
    .m_index       (m_index),
    .m_last        (m_last),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  // Identity core: CL-deep register pipeline.
  logic [8*W-1:0] pipe_r [CL];
  logic [8*W-1:0] pipe_i [CL];
  always_ff @(posedge clk) begin
    pipe_r[0] <= core_in_real;
    pipe_i[0] <= core_in_imag;
    for (int k = 1; k < CL; k++) begin
      pipe_r[k] <= pipe_r[k-1];
      pipe_i[k] <= pipe_i[k-1];
    end
  end
  assign core_out_real = pipe_r[CL-1];
  assign core_out_imag = pipe_i[CL-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          nframes  = 0;
  int          exp_idx  = 0;
  logic [31:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: scoreboard at negedge, then advance to just after posedge.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    if (rst_n && flush) begin
      sb.delete();
      exp_idx = 0;
    end else if (rst_n) begin
      if (s_valid && s_ready) sb.push_back({s_real, s_imag});
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(m_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("m_data", 64'({m_real, m_imag}), 64'(e));
          chk("m_index", 64'(m_index), 64'(exp_idx));
          chk("m_last", 64'(m_last), 64'(exp_idx == 7));
          chk("frame_done", 64'(frame_done), 64'(exp_idx == 7));
          exp_idx = (exp_idx + 1) % 8;
        end
      end
      if (frame_done) nframes++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [W-1:0] r, input logic [W-1:0] i);
    int n;
    n       = 0;
    s_real  = r;
    s_imag  = i;
    s_valid = 1'b1;
    while (!s_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("s_ready_timeout", 64'(s_ready), 64'(1));
    step();
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] br, input logic [W-1:0] bi);
    for (int k = 0; k < 8; k++) send_beat(br + W'(k), bi + W'(k));
  endtask

  task automatic wait_mvalid();
    int n;
    n = 0;
    while (!m_valid && n < 100) begin
      step();
      n++;
    end
    chk("wait_m_valid", 64'(m_valid), 64'(1));
  endtask

  task automatic drain_to(input int target);
    int n;
    n = 0;
    while (nframes < target && n < 500) begin
      step();
      n++;
    end
    chk("drain_frames", 64'(nframes), 64'(target));
    chk("sb_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    int start;
    int beats_sent;
    int n;

    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    s_real = '0; s_imag = '0;
    #7;
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_core_start", 64'(core_start), 64'(0));
    chk("rst_m_index", 64'(m_index), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_core_in", 64'(core_in_real[63:0]), 64'(0));
    chk("rst_m_data", 64'({m_real, m_imag}), 64'(0));
    @(posedge clk); #1;
    step();
    rst_n = 1'b1;
    step();

    // Basic frame: real 1..8, imag -1..-8, latency and single start pulse.
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) send_beat(W'(k + 1), W'(-(k + 1)));
    chk("t1_core_start", 64'(core_start), 64'(1));
    chk("t1_s_ready", 64'(s_ready), 64'(0));
    chk("t1_busy", 64'(busy), 64'(1));
    step();
    chk("t2_core_start", 64'(core_start), 64'(0));
    step();
    step();
    chk("t4_m_valid", 64'(m_valid), 64'(0));
    step();
    chk("t5_m_valid", 64'(m_valid), 64'(1));
    chk("t5_s_ready", 64'(s_ready), 64'(1));
    chk("t5_bin0", 64'({m_real, m_imag}), 64'({16'd1, 16'hFFFF}));
    drain_to(1);

    // Backpressure: frame B waits in WAIT_OUT until frame A drains.
    m_ready = 1'b0;
    send_frame(16'h0100, 16'h0200);
    wait_mvalid();
    send_frame(16'h0300, 16'h0400);
    step();
    chk("bp_s_ready", 64'(s_ready), 64'(0));
    chk("bp_busy", 64'(busy), 64'(1));
    step(); step(); step();
    chk("bp_hold_valid", 64'(m_valid), 64'(1));
    chk("bp_hold_index", 64'(m_index), 64'(0));
    chk("bp_hold_data", 64'({m_real, m_imag}), 64'({16'h0100, 16'h0200}));
    chk("bp_no_start", 64'(core_start), 64'(0));
    m_ready = 1'b1;
    drain_to(3);

    // Last output beat and 8th input beat coincide: RUN immediately.
    m_ready = 1'b0;
    send_frame(16'h0500, 16'h0600);
    wait_mvalid();
    m_ready = 1'b1;
    send_frame(16'h0700, 16'h0800);
    chk("sim_core_start", 64'(core_start), 64'(1));
    chk("sim_s_ready", 64'(s_ready), 64'(0));
    drain_to(5);

    // Flush after 5 input beats.
    for (int k = 0; k < 5; k++) send_beat(W'(16'h0900 + k), W'(16'h0A00 + k));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl1_s_ready", 64'(s_ready), 64'(1));
    chk("fl1_busy", 64'(busy), 64'(0));
    for (int k = 0; k < 8; k++) step();
    chk("fl1_no_m_valid", 64'(m_valid), 64'(0));
    send_frame(16'h0B00, 16'h0C00);
    drain_to(6);

    // Flush during drain at bin 3.
    send_frame(16'h0D00, 16'h0E00);
    n = 0;
    while (!(m_valid && m_index == 3'd3) && n < 100) begin
      step();
      n++;
    end
    chk("fl2_at_bin3", 64'(m_index), 64'(3));
    start = nframes;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl2_m_valid", 64'(m_valid), 64'(0));
    chk("fl2_s_ready", 64'(s_ready), 64'(1));
    for (int k = 0; k < 6; k++) step();
    chk("fl2_no_m_valid", 64'(m_valid), 64'(0));
    chk("fl2_no_frame_done", 64'(nframes), 64'(start));
    send_frame(16'h0F00, 16'h1000);
    drain_to(start + 1);

    // Async reset in the middle of RUN.
    send_frame(16'h1100, 16'h1200);
    step();
    rst_n = 1'b0;
    sb.delete();
    exp_idx = 0;
    #1;
    chk("rr_s_ready", 64'(s_ready), 64'(1));
    chk("rr_m_valid", 64'(m_valid), 64'(0));
    chk("rr_core_start", 64'(core_start), 64'(0));
    chk("rr_busy", 64'(busy), 64'(0));
    chk("rr_core_in", 64'(core_in_real[63:0]), 64'(0));
    step(); step();
    rst_n = 1'b1;
    start = nframes;
    send_frame(16'h1300, 16'h1400);
    drain_to(start + 1);

    // Random valid/ready toggling over 50 frames.
    start      = nframes;
    beats_sent = 0;
    n          = 0;
    while ((beats_sent < 400 || nframes < start + 50) && n < 20000) begin
      s_valid = (beats_sent < 400) && ($urandom_range(0, 3) != 0);
      s_real  = W'($urandom);
      s_imag  = W'($urandom);
      m_ready = ($urandom_range(0, 2) != 0);
      if (s_valid && s_ready) beats_sent++;
      step();
      n++;
    end
    s_valid = 1'b0;
    chk("rand_frame_done_count", 64'(nframes - start), 64'(50));
    chk("rand_sb_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft8_frame_sequencer.md
# fft8_frame_sequencer

Streaming front/back-end controller for the 8-point FFT pipeline. It collects one complex sample per handshake into an 8-entry input frame and launches the parallel 3-stage FFT core. It captures the core outputs after the fixed core latency and streams the 8 results out on a ready/valid interface. A new frame may fill while the previous result frame drains.

## Interface
- WIDTH, 16, sample component width (signed, two's complement)
- CORE_LATENCY, 3, cycles from inputs stable at core to core outputs valid (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous; discards partial input frame, pending launch and output frame
- s_valid  in  1  input sample valid
- s_ready  out  1  sequencer can accept an input sample
- s_real, s_imag  in  WIDTH  input sample, time index = arrival order 0..7
- core_in_real, core_in_imag  out  8*WIDTH  parallel core inputs, index n at bits [n*WIDTH +: WIDTH]
- core_start  out  1  one-cycle pulse in the first RUN cycle
- core_out_real, core_out_imag  in  8*WIDTH  parallel core outputs, same packing
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts output sample
- m_real, m_imag  out  WIDTH  output sample for bin m_index
- m_index  out  3  bin index 0..7
- m_last  out  1  high with bin 7
- frame_done  out  1  one-cycle pulse when bin 7 is accepted
- busy  out  1  high when not in FILL with fill count 0 and output empty

## Operation
- Input FSM states: FILL, WAIT_OUT, RUN.
- FILL: s_ready=1. Each s_valid&&s_ready writes entry fill_cnt and increments it. The 8th beat wraps fill_cnt to 0. After the 8th beat, the FSM goes to RUN if out_full=0 or the final output beat is accepted in the same cycle; otherwise it goes to WAIT_OUT.
- WAIT_OUT: s_ready=0. Go to RUN when out_full=0.
- RUN: s_ready=0. The input buffer is held constant. lat_cnt counts 0..CORE_LATENCY. When lat_cnt==CORE_LATENCY, all 8 core_out entries are captured into the output buffer, out_full is set, rd_idx is reset to 0, and the FSM returns to FILL.
- Output side: m_valid=out_full. m_real/m_imag/m_index come from entry rd_idx. Each m_valid&&m_ready increments rd_idx. The beat with rd_idx=7 clears out_full and pulses frame_done.
- The core's own valid/done outputs are not used. Sequencing relies only on CORE_LATENCY.
- flush: the FSM goes to FILL, and fill_cnt, lat_cnt, rd_idx and out_full are cleared. Buffer contents are not cleared. flush has priority over all handshakes in that cycle.
- No arithmetic is performed. Data passes bit-exact from input to core and from core to output.

## Timing
- Reset values: s_ready=1, m_valid=0, core_start=0, m_index=0, m_last=0, frame_done=0, busy=0. Data outputs and buffers are 0.
- Let the 8th input beat be accepted in cycle t, with output empty:
  - RUN starts in t+1, with core_start=1 in t+1.
  - Capture happens at the edge ending t+1+CORE_LATENCY.
  - m_valid is first high and s_ready returns high in t+2+CORE_LATENCY, which is t+5 by default.
- With m_ready=1, bins 0..7 come out in 8 consecutive cycles. When m_ready=0, outputs hold stable.
- Steady state, with producer and consumer always ready: one frame every 8+1+CORE_LATENCY cycles, limited by input.
- Stalls and boundaries:
  - s_valid is ignored while s_ready=0.
  - A partial frame never launches.
  - rst_n asserted mid-RUN or mid-drain clears everything immediately, with no output beat.

## Structure
- Shared package fft8_pkg holds:
  - state enum {FILL, WAIT_OUT, RUN}
  - FFT_POINTS=8 and IDX_W=3
  - default CORE_LATENCY=3
- No sub-module. Both 8-entry complex buffers, the input and output FSMs and the counters sit inline (about 200 lines).
- The top level instantiates this block beside the FFT core.

## Test plan
- Identity stub core (CORE_LATENCY-deep register on core_in→core_out). Input real=1..8, imag=-1..-8, m_ready=1 → output bins 0..7 are real 1..8 / imag -1..-8. m_last is high only on bin 7. The first m_valid is 5 cycles after the 8th input beat. core_start is a single pulse.
- Backpressure: m_ready=0 during frame 2 fill → after the 8th beat of frame 2 the FSM sits in WAIT_OUT with s_ready=0. Raising m_ready drains frame 1 unchanged, then frame 2 launches. No data is lost or reordered.
- Simultaneous events: the last output beat of frame 1 and the 8th input beat of frame 2 in the same cycle → RUN next cycle, no WAIT_OUT cycle.
- Random s_valid/m_ready toggling over 50 frames → output stream equals input stream framewise. frame_done count = 50.
- flush after 5 input beats, and separately during drain at bin 3 → no further m_valid, s_ready=1 next cycle, and the following full frame is processed correctly.
- rst_n pulse mid-RUN → all outputs at reset values the same cycle. After release, a fresh frame completes normally.
